// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory and fetch/decode logic.
package imem_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    HALT  = 2'd3
  } imem_state_e;

  // addi x0,x0,0 -- used both as RAM fill value and as pipeline bubble
  localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
  localparam logic [31:0] HALT_WORD = 32'hffff_ffff;

  typedef struct packed {
    logic        ok;   // aligned and inside the memory
    logic [31:0] idx;  // word index, already masked to addr_w bits
  } word_idx_t;

  // Turn a byte PC into a word index plus an aligned/in-range flag.
  function automatic word_idx_t word_index(input logic [63:0] pc, input int unsigned addr_w);
    word_idx_t   r;
    logic [63:0] hi;
    logic [63:0] mask;
    hi    = pc >> (addr_w + 32'd2);
    mask  = (64'd1 << addr_w) - 64'd1;
    r.ok  = (pc[1:0] == 2'b00) && (hi == 64'd0);
    r.idx = 32'((pc >> 2) & mask);
    return r;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x DATA_W RAM: one synchronous write port, one registered read port.
// The array carries no reset so it can map onto block RAM.
module imem_ram #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; holds its last value while re_i is low
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory for the fetch stage: clears to NOP after reset,
// accepts a word-serial program load, then serves fetches with one-cycle
// latency, stall/flush handling, bad-PC protection and sticky halt detection.
module imem_loadable import imem_pkg::*; #(
  parameter int          ADDR_W    = 5,
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_WORD  = imem_pkg::NOP_WORD,
  parameter logic [31:0] HALT_WORD = imem_pkg::HALT_WORD
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [31:0]       ld_data_i,
  output logic              ld_ready_o,
  input  logic              ld_done_i,
  input  logic [PC_W-1:0]   fetch_pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [31:0]       instr_o,
  output logic [PC_W-1:0]   instr_pc_o,
  output logic              instr_valid_o,
  output logic              running_o,
  output logic              halted_o
);

  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

  imem_state_e       state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              nop_sel_q;      // output shows NOP_WORD instead of RAM data
  logic [PC_W-1:0]   instr_pc_q;
  logic              instr_valid_q;
  logic              running_q;
  logic              halted_q;
  logic              ld_ready_q;

  word_idx_t         wi_s;
  logic              unused_idx_s;
  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_waddr_s;
  logic [31:0]       ram_wdata_s;
  logic              ram_re_s;
  logic [ADDR_W-1:0] ram_raddr_s;
  logic [31:0]       ram_rdata_s;
  logic [31:0]       instr_s;
  logic              halt_hit_s;

  assign wi_s         = word_index(64'(fetch_pc_i), ADDR_W);
  assign unused_idx_s = ^wi_s.idx[31:ADDR_W];

  // RAM port control: CLEAR walks the counter, LOAD takes the load port, RUN reads
  always_comb begin
    ram_we_s    = 1'b0;
    ram_waddr_s = cnt_q;
    ram_wdata_s = NOP_WORD;
    ram_re_s    = 1'b0;
    ram_raddr_s = wi_s.idx[ADDR_W-1:0];
    case (state_q)
      CLEAR: begin
        ram_we_s = 1'b1;
      end
      LOAD: begin
        ram_we_s    = ld_valid_i;
        ram_waddr_s = ld_addr_i;
        ram_wdata_s = ld_data_i;
      end
      RUN: begin
        ram_re_s = flush_i || !stall_i;
      end
      default: begin
        ram_re_s = 1'b0;
      end
    endcase
  end

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we_s),
    .waddr_i (ram_waddr_s),
    .wdata_i (ram_wdata_s),
    .re_i    (ram_re_s),
    .raddr_i (ram_raddr_s),
    .rdata_o (ram_rdata_s)
  );

  // Output mux between registered RAM data and the NOP bubble (both registered sources)
  always_comb begin
    if (nop_sel_q) begin
      instr_s = NOP_WORD;
    end else begin
      instr_s = ram_rdata_s;
    end
  end

  // A valid, non-stalled HALT_WORD on the output stops the core
  assign halt_hit_s = (state_q == RUN) && instr_valid_q && !stall_i && (instr_s == HALT_WORD);

  // Main FSM with clear counter, fetch output registers and halt tracking
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= CLEAR;
      cnt_q         <= {ADDR_W{1'b0}};
      nop_sel_q     <= 1'b1;
      instr_pc_q    <= {PC_W{1'b0}};
      instr_valid_q <= 1'b0;
      running_q     <= 1'b0;
      halted_q      <= 1'b0;
      ld_ready_q    <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q    <= LOAD;
            ld_ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (ld_done_i) begin
            state_q    <= RUN;
            ld_ready_q <= 1'b0;
            running_q  <= 1'b1;
          end
        end
        RUN: begin
          if (halt_hit_s) begin
            state_q       <= HALT;
            running_q     <= 1'b0;
            halted_q      <= 1'b1;
            instr_valid_q <= 1'b0;
            nop_sel_q     <= 1'b1;
          end else if (flush_i) begin
            // flush wins over stall: bubble out, but still track the PC
            nop_sel_q     <= 1'b1;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= fetch_pc_i;
          end else if (!stall_i) begin
            nop_sel_q     <= !wi_s.ok;
            instr_valid_q <= 1'b1;
            instr_pc_q    <= fetch_pc_i;
          end
        end
        HALT: begin
          nop_sel_q     <= 1'b1;
          instr_valid_q <= 1'b0;
          halted_q      <= 1'b1;
          running_q     <= 1'b0;
        end
        default: begin
          state_q <= CLEAR;
          cnt_q   <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  assign instr_o       = instr_s;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = instr_valid_q;
  assign running_o     = running_q;
  assign halted_o      = halted_q;
  assign ld_ready_o    = ld_ready_q;

endmodule

// File: tb/tb_imem_loadable.sv
// Directed testbench for imem_loadable (ADDR_W=5 main instance, ADDR_W=8 for CLEAR length).
module tb_imem_loadable;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_addr = 5'd0;
  logic [31:0] ld_data = 32'd0;
  logic        ld_done = 1'b0;
  logic [31:0] fetch_pc = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        ld_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        running;
  logic        halted;

  logic        rst8 = 1'b1;
  logic        ld_ready8;
  logic [31:0] instr8;
  logic [31:0] instr_pc8;
  logic        instr_valid8;
  logic        running8;
  logic        halted8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imem_loadable #(.ADDR_W(5), .PC_W(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
    .ld_ready_o(ld_ready), .ld_done_i(ld_done), .fetch_pc_i(fetch_pc), .stall_i(stall),
    .flush_i(flush), .instr_o(instr), .instr_pc_o(instr_pc), .instr_valid_o(instr_valid),
    .running_o(running), .halted_o(halted)
  );

  imem_loadable #(.ADDR_W(8), .PC_W(32)) u_dut8 (
    .clk_i(clk), .rst_i(rst8), .ld_valid_i(1'b0), .ld_addr_i(8'd0), .ld_data_i(32'd0),
    .ld_ready_o(ld_ready8), .ld_done_i(1'b0), .fetch_pc_i(32'd0), .stall_i(1'b0),
    .flush_i(1'b0), .instr_o(instr8), .instr_pc_o(instr_pc8), .instr_valid_o(instr_valid8),
    .running_o(running8), .halted_o(halted8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load();
    int n = 0;
    while (!ld_ready && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_load: ld_ready=%b after %0d cycles, required 1", ld_ready, n);
    end
  endtask

  task automatic pulse_reset();
    ld_valid = 1'b0; ld_done = 1'b0; stall = 1'b0; flush = 1'b0; fetch_pc = 32'd0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    wait_load();
  endtask

  task automatic go_run();
    ld_valid = 1'b0;
    ld_done  = 1'b1;
    step();
    ld_done  = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] exp_i, input logic exp_v, input string nm);
    fetch_pc = pc;
    step();
    checks++;
    if (instr !== exp_i || instr_pc !== pc || instr_valid !== exp_v) begin
      errors++;
      $display("FAIL %s: instr=%h pc=%h valid=%b, required instr=%h pc=%h valid=%b",
               nm, instr, instr_pc, instr_valid, exp_i, pc, exp_v);
    end
  endtask

  task automatic test_reset();
    int n = 0;
    step();
    checks++;
    if (instr !== 32'h0000_0013 || instr_pc !== 32'd0 || instr_valid !== 1'b0 ||
        running !== 1'b0 || halted !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: instr=%h pc=%h v=%b run=%b halt=%b rdy=%b, required 00000013/0/0/0/0/0",
               instr, instr_pc, instr_valid, running, halted, ld_ready);
    end
    rst = 1'b0;
    while (!ld_ready && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL clear_len32: CLEAR took %0d cycles, required 32", n);
    end
  endtask

  task automatic test_empty_fetch();
    go_run();
    checks++;
    if (running !== 1'b1 || instr_valid !== 1'b0 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL enter_run: run=%b valid=%b rdy=%b, required 1/0/0", running, instr_valid, ld_ready);
    end
    fetch(32'd28, 32'h0000_0013, 1'b1, "empty_word7");
  endtask

  task automatic test_load_fetch();
    pulse_reset();
    ld_valid = 1'b1;
    ld_addr = 5'd0; ld_data = 32'h0030_0513; step();
    ld_addr = 5'd1; ld_data = 32'h0140_00ef; step();
    ld_addr = 5'd3; ld_data = 32'h1111_1111; step();
    ld_addr = 5'd3; ld_data = 32'h2222_2222; step();
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL ld_ready_load: ld_ready=%b, required 1", ld_ready);
    end
    ld_addr = 5'd5; ld_data = 32'hffff_ffff; ld_done = 1'b1; step();
    ld_done = 1'b0;
    checks++;
    if (ld_ready !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL load_to_run: rdy=%b run=%b, required 0/1", ld_ready, running);
    end
    // load port must be ignored in RUN
    ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'haaaa_aaaa;
    fetch(32'd0, 32'h0030_0513, 1'b1, "fetch_pc0");
    ld_valid = 1'b0;
    fetch(32'd4, 32'h0140_00ef, 1'b1, "fetch_pc4");
    fetch(32'd8, 32'h0000_0013, 1'b1, "fetch_pc8");
    fetch(32'd12, 32'h2222_2222, 1'b1, "last_write_wins");
    fetch(32'd0, 32'h0030_0513, 1'b1, "run_load_ignored");
  endtask

  task automatic test_stall_flush();
    fetch(32'd4, 32'h0140_00ef, 1'b1, "pre_stall");
    stall = 1'b1;
    fetch_pc = 32'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (instr !== 32'h0140_00ef || instr_pc !== 32'd4 || instr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: instr=%h pc=%h v=%b, required 014000ef/4/1", i, instr, instr_pc, instr_valid);
      end
    end
    flush = 1'b1;
    fetch(32'd8, 32'h0000_0013, 1'b0, "flush_over_stall");
    stall = 1'b0; flush = 1'b0;
    fetch(32'd0, 32'h0030_0513, 1'b1, "after_flush");
  endtask

  task automatic test_bad_pc();
    fetch(32'h0000_0002, 32'h0000_0013, 1'b1, "misaligned");
    fetch(32'h0000_0080, 32'h0000_0013, 1'b1, "out_of_range");
  endtask

  task automatic test_halt();
    flush = 1'b1;
    fetch(32'h14, 32'h0000_0013, 1'b0, "flushed_halt");
    flush = 1'b0;
    fetch(32'd0, 32'h0030_0513, 1'b1, "flushed_halt_next");
    checks++;
    if (halted !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL flushed_no_halt: halted=%b run=%b, required 0/1", halted, running);
    end
    fetch(32'h14, 32'hffff_ffff, 1'b1, "halt_word");
    fetch_pc = 32'd4;
    step();
    checks++;
    if (halted !== 1'b1 || running !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin
      errors++;
      $display("FAIL halt_enter: halted=%b run=%b v=%b instr=%h, required 1/0/0/00000013",
               halted, running, instr_valid, instr);
    end
    fetch_pc = 32'd0;
    step(); step();
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin
      errors++;
      $display("FAIL halt_sticky: halted=%b v=%b instr=%h, required 1/0/00000013", halted, instr_valid, instr);
    end
  endtask

  task automatic test_reset_mid_load();
    pulse_reset();
    ld_valid = 1'b1;
    ld_addr = 5'd0; ld_data = 32'h1234_5678; step();
    ld_addr = 5'd9; ld_data = 32'hcafe_f00d; step();
    ld_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ld_ready !== 1'b0 || running !== 1'b0 || halted !== 1'b0 || instr_valid !== 1'b0 ||
        instr !== 32'h0000_0013 || instr_pc !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b run=%b halt=%b v=%b instr=%h pc=%h, required 0/0/0/0/00000013/0",
               ld_ready, running, halted, instr_valid, instr, instr_pc);
    end
    #1;
    rst = 1'b0;
    wait_load();
    go_run();
    fetch(32'd0, 32'h0000_0013, 1'b1, "cleared_word0");
    fetch(32'd36, 32'h0000_0013, 1'b1, "cleared_word9");
  endtask

  task automatic test_depth256();
    int n = 0;
    rst8 = 1'b1;
    step();
    checks++;
    if (ld_ready8 !== 1'b0 || running8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: rdy=%b run=%b, required 0/0", ld_ready8, running8);
    end
    rst8 = 1'b0;
    while (!ld_ready8 && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (n !== 256) begin
      errors++;
      $display("FAIL clear_len256: CLEAR took %0d cycles, required 256", n);
    end
  endtask

  initial begin
    test_reset();
    test_empty_fetch();
    test_load_fetch();
    test_stall_flush();
    test_bad_pc();
    test_halt();
    test_reset_mid_load();
    test_depth256();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
# imem_loadable

Parametrised, loadable instruction memory for the pipelined CPU fetch stage. It replaces a fixed combinational program table with a synchronous-read RAM. The RAM is cleared to NOP after reset, filled over a word-serial load port, then serves fetches with one-cycle latency. Fetch supports stall, flush, out-of-range/misaligned protection and sticky halt detection.

## Interface
- ADDR_W, 5: word-address width; DEPTH = 2**ADDR_W words
- PC_W, 32: width of fetch byte PC
- NOP_WORD, 32'h0000_0013: fill/bubble word (addi x0,x0,0)
- HALT_WORD, 32'hffff_ffff: halt encoding
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ld_valid  in  1  load word present
- ld_addr  in  ADDR_W  load word address
- ld_data  in  32  load word
- ld_ready  out  1  load word accepted this cycle when ld_valid=1
- ld_done  in  1  end of program load, enter RUN
- fetch_pc  in  PC_W  byte PC of requested instruction
- stall  in  1  hold current instr/pc outputs
- flush  in  1  replace next output with NOP_WORD
- instr  out  32  fetched instruction
- instr_pc  out  PC_W  PC that produced instr
- instr_valid  out  1  instr is a real fetch result
- running  out  1  state == RUN
- halted  out  1  sticky: HALT_WORD has been issued

## Operation
- FSM states: CLEAR, LOAD, RUN, HALT. Reset enters CLEAR with clear counter = 0.
- CLEAR: writes NOP_WORD to word[counter] each cycle. After writing DEPTH-1, go to LOAD. Takes exactly DEPTH cycles. ld_ready=0. ld_done is ignored.
- LOAD: ld_ready=1. When ld_valid=1, mem[ld_addr] <= ld_data. If ld_done=1 (with or without ld_valid in the same cycle), write any word first, then go to RUN next cycle. Words never loaded stay NOP_WORD.
- RUN: ld_ready=0, and load inputs are ignored. Each non-stalled cycle registers a read of word fetch_pc[ADDR_W+1:2].
  - If fetch_pc[1:0]!=0, or fetch_pc[PC_W-1:ADDR_W+2]!=0, the output is NOP_WORD.
  - instr_pc <= fetch_pc; instr_valid <= 1.
- stall=1 in RUN: instr, instr_pc and instr_valid hold, and fetch_pc is ignored.
- flush=1 in RUN: next instr = NOP_WORD and instr_valid = 0. instr_pc still latches fetch_pc. flush overrides stall.
- Halt: in RUN, when the registered output is HALT_WORD with instr_valid=1 and stall=0, go to HALT next cycle and set halted=1.
- HALT: halted=1 and instr_valid=0. instr = NOP_WORD from the first HALT cycle onward. Only reset leaves HALT.
- A flushed HALT_WORD is never produced, because a flush turns it into NOP_WORD, so it does not halt.

## Timing
- Reset values (asynchronous, on rst high): state=CLEAR, counter=0, instr=NOP_WORD, instr_pc=0, instr_valid=0, running=0, halted=0, ld_ready=0.
- Reset mid-CLEAR, mid-LOAD or mid-RUN: all state is reinitialised and CLEAR restarts from word 0. Memory contents are not guaranteed until CLEAR completes.
- Fetch latency: fetch_pc sampled at edge N produces instr/instr_pc valid after edge N; a consumer sees it in cycle N+1.
- First fetch sample happens on the first edge where state==RUN. The cycle the FSM enters RUN, instr_valid is still 0.
- Load throughput: one word per cycle. Writes to the same address in consecutive cycles: the last one wins.
- running and halted are registered outputs and update on the state-change edge.
- There is no read-during-write case, because writes occur only in CLEAR/LOAD and reads only in RUN.

## Structure
- Shared package imem_pkg: state enum {CLEAR, LOAD, RUN, HALT}, NOP_WORD and HALT_WORD constants (also used by decode), and a function word_index(pc) returning the index plus an in-range/aligned flag.
- One sub-module, imem_ram: DEPTH x 32 RAM, single write port, registered single read port. It has no reset on the array so it can infer block RAM.
- Top-level imem_loadable holds the FSM, clear counter, output/bypass muxing for NOP and stall, and halt detection.

## Test plan
- Reset then idle: CLEAR lasts exactly DEPTH=32 cycles, then ld_ready=1. Fetching word 7 after ld_done with nothing loaded returns 32'h0000_0013.
- Load the factorial program (word0=32'h00300513, word1=32'h014000ef, word5=32'hffffffff) then ld_done. Fetch pc 0, 4, 8: outputs arrive one cycle later as 00300513, 014000ef, 00000013, with instr_pc matching.
- Stall and flush: stall for 3 cycles holds instr=014000ef. flush together with stall yields NOP_WORD with instr_valid=0.
- Bad PC: fetch_pc=0x2 and fetch_pc=0x80 (ADDR_W=5) each return NOP_WORD with instr_valid=1.
- Halt: fetch pc 0x14 returns ffffffff. halted=1 on the next edge, instr_valid stays 0, and later fetches are ignored. The same fetch with flush=1 does not halt.
- Reset asserted mid-LOAD (asynchronously, between edges): outputs immediately return to reset values, and previously loaded words read back as NOP after CLEAR. Repeat with ADDR_W=8 and check that CLEAR lasts 256 cycles.
